// File: rtl/hmmm_io_port.sv
// CPU-side I/O port for the HMMM core: an input FIFO feeding READ and an output
// FIFO fed by WRITE, with stall when the core's request cannot be serviced.
module hmmm_io_port #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_rd_req,
  input  logic                     cpu_wr_req,
  input  logic [15:0]              cpu_wdata,
  output logic [15:0]              cpu_rdata,
  output logic                     cpu_stall,
  input  logic                     in_valid,
  input  logic [15:0]              in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [15:0]              out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   in_count,
  output logic [$clog2(DEPTH):0]   out_count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [15:0]   in_mem  [DEPTH];
  logic [15:0]   out_mem [DEPTH];
  logic [AW-1:0] in_wptr, in_rptr, out_wptr, out_rptr;

  logic cpu_rd_only, cpu_wr_only;
  logic in_empty, in_full, out_empty, out_full;
  logic in_push, in_pop, out_push, out_pop;

  // All handshakes use start-of-cycle counts, so a full FIFO never accepts a
  // push in the same cycle it is popped, and an empty FIFO never bypasses.
  assign cpu_rd_only = cpu_rd_req && !cpu_wr_req;
  assign cpu_wr_only = cpu_wr_req && !cpu_rd_req;
  assign in_empty    = (in_count == '0);
  assign in_full     = (in_count == FULL);
  assign out_empty   = (out_count == '0);
  assign out_full    = (out_count == FULL);

  assign in_push  = in_valid && !in_full;
  assign in_pop   = cpu_rd_only && !in_empty;
  assign out_push = cpu_wr_only && !out_full;
  assign out_pop  = !out_empty && out_ready;

  assign in_ready  = !in_full;
  assign out_valid = !out_empty;
  assign cpu_rdata = in_empty ? 16'h0000 : in_mem[in_rptr];
  assign out_data  = out_mem[out_rptr];
  assign cpu_stall = (cpu_rd_only && in_empty) || (cpu_wr_only && out_full);

  always_ff @(posedge clk) begin
    if (reset) begin
      in_wptr   <= '0;
      in_rptr   <= '0;
      in_count  <= '0;
      out_wptr  <= '0;
      out_rptr  <= '0;
      out_count <= '0;
      err       <= 1'b0;
    end else begin
      if (in_push) in_wptr <= in_wptr + AW'(1);
      if (in_pop)  in_rptr <= in_rptr + AW'(1);
      case ({in_push, in_pop})
        2'b10:   in_count <= in_count + CW'(1);
        2'b01:   in_count <= in_count - CW'(1);
        default: in_count <= in_count;
      endcase

      if (out_push) out_wptr <= out_wptr + AW'(1);
      if (out_pop)  out_rptr <= out_rptr + AW'(1);
      case ({out_push, out_pop})
        2'b10:   out_count <= out_count + CW'(1);
        2'b01:   out_count <= out_count - CW'(1);
        default: out_count <= out_count;
      endcase

      // Simultaneous READ and WRITE is a core protocol violation; flag it sticky.
      if (cpu_rd_req && cpu_wr_req) err <= 1'b1;
    end
  end

  // Storage carries no reset; the cleared pointers and counts discard contents.
  always_ff @(posedge clk) begin
    if (!reset && in_push)  in_mem[in_wptr]   <= in_data;
    if (!reset && out_push) out_mem[out_wptr] <= cpu_wdata;
  end

endmodule

// File: tb/tb_hmmm_io_port.sv
// Bench for hmmm_io_port: directed vector table for the corner cases, then
// randomized traffic checked against a queue-based model of the port.
module tb_hmmm_io_port;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_rd_req, cpu_wr_req;
  logic [15:0]   cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          in_valid;
  logic [15:0]   in_data;
  logic          in_ready;
  logic          out_valid;
  logic [15:0]   out_data;
  logic          out_ready;
  logic [CW-1:0] in_count, out_count;
  logic          err;

  int vectors    = 0;
  int miscompares = 0;

  hmmm_io_port #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd_req(cpu_rd_req), .cpu_wr_req(cpu_wr_req),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .in_count(in_count), .out_count(out_count), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, rd, wr;
    logic [15:0] wdata;
    logic        iv;
    logic [15:0] idata;
    logic        ordy;
    logic [15:0] p_rdata;
    logic        p_stall, p_inrdy, p_ovalid;
    logic [15:0] p_odata;
    int          q_in, q_out;
    logic        q_err;
  } vec_t;

  vec_t tbl[$];

  // Row layout: inputs, then pre-edge outputs, then post-edge counts and err.
  function automatic void add(input int rst, rd, wr, wdata, iv, idata, ordy,
                              input int p_rdata, p_stall, p_inrdy, p_ovalid, p_odata,
                              input int q_in, q_out, q_err);
    vec_t v;
    v.rst = 1'(rst);  v.rd = 1'(rd);  v.wr = 1'(wr);  v.wdata = 16'(wdata);
    v.iv = 1'(iv);  v.idata = 16'(idata);  v.ordy = 1'(ordy);
    v.p_rdata = 16'(p_rdata);  v.p_stall = 1'(p_stall);  v.p_inrdy = 1'(p_inrdy);
    v.p_ovalid = 1'(p_ovalid);  v.p_odata = 16'(p_odata);
    v.q_in = q_in;  v.q_out = q_out;  v.q_err = 1'(q_err);
    tbl.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, rd, wr, input logic [15:0] wdata,
                               input logic iv, input logic [15:0] idata, input logic ordy);
    @(negedge clk);
    reset = rst;  cpu_rd_req = rd;  cpu_wr_req = wr;  cpu_wdata = wdata;
    in_valid = iv;  in_data = idata;  out_ready = ordy;
    #1;
  endtask

  // Behavioural reference: two bounded queues and a sticky error bit.
  logic [15:0] in_q[$];
  logic [15:0] out_q[$];
  logic        m_err;

  task automatic checkModel(input int idx);
    logic        exp_stall;
    logic [15:0] exp_rdata;
    exp_rdata = (in_q.size() > 0) ? in_q[0] : 16'h0000;
    exp_stall = (cpu_rd_req && !cpu_wr_req && in_q.size() == 0) ||
                (cpu_wr_req && !cpu_rd_req && out_q.size() == DEPTH);
    checkOutput($sformatf("rnd%0d cpu_rdata", idx), cpu_rdata, exp_rdata);
    checkOutput($sformatf("rnd%0d cpu_stall", idx), 16'(cpu_stall), 16'(exp_stall));
    checkOutput($sformatf("rnd%0d in_ready", idx), 16'(in_ready), 16'(in_q.size() < DEPTH));
    checkOutput($sformatf("rnd%0d out_valid", idx), 16'(out_valid), 16'(out_q.size() > 0));
    if (out_q.size() > 0)
      checkOutput($sformatf("rnd%0d out_data", idx), out_data, out_q[0]);
    checkOutput($sformatf("rnd%0d in_count", idx), 16'(in_count), 16'(in_q.size()));
    checkOutput($sformatf("rnd%0d out_count", idx), 16'(out_count), 16'(out_q.size()));
    checkOutput($sformatf("rnd%0d err", idx), 16'(err), 16'(m_err));
  endtask

  function automatic void modelStep();
    bit do_in_push, do_in_pop, do_out_push, do_out_pop;
    if (reset) begin
      in_q.delete();
      out_q.delete();
      m_err = 1'b0;
      return;
    end
    do_in_push  = in_valid && in_q.size() < DEPTH;
    do_in_pop   = cpu_rd_req && !cpu_wr_req && in_q.size() > 0;
    do_out_push = cpu_wr_req && !cpu_rd_req && out_q.size() < DEPTH;
    do_out_pop  = out_ready && out_q.size() > 0;
    if (do_in_pop)   void'(in_q.pop_front());
    if (do_in_push)  in_q.push_back(in_data);
    if (do_out_pop)  void'(out_q.pop_front());
    if (do_out_push) out_q.push_back(cpu_wdata);
    if (cpu_rd_req && cpu_wr_req) m_err = 1'b1;
  endfunction

  initial begin
    reset = 1'b1;  cpu_rd_req = 1'b0;  cpu_wr_req = 1'b0;  cpu_wdata = '0;
    in_valid = 1'b0;  in_data = '0;  out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    add(1,0,0,0,0,0,0,        0,0,1,0,0,        0,0,0);
    // push 5, 7 then two READs
    add(0,0,0,0,1,5,0,        0,0,1,0,0,        1,0,0);
    add(0,0,0,0,1,7,0,        5,0,1,0,0,        2,0,0);
    add(0,1,0,0,0,0,0,        5,0,1,0,0,        1,0,0);
    add(0,1,0,0,0,0,0,        7,0,1,0,0,        0,0,0);
    // READ on empty stalls, push AA visible one cycle later
    add(0,1,0,0,0,0,0,        0,1,1,0,0,        0,0,0);
    add(0,1,0,0,0,0,0,        0,1,1,0,0,        0,0,0);
    add(0,1,0,0,0,0,0,        0,1,1,0,0,        0,0,0);
    add(0,1,0,0,1,'hAA,0,     0,1,1,0,0,        1,0,0);
    add(0,1,0,0,0,0,0,        'hAA,0,1,0,0,     0,0,0);
    // WRITE 1..5 into a blocked sink, then drain
    add(0,0,1,1,0,0,0,        0,0,1,0,0,        0,1,0);
    add(0,0,1,2,0,0,0,        0,0,1,1,1,        0,2,0);
    add(0,0,1,3,0,0,0,        0,0,1,1,1,        0,3,0);
    add(0,0,1,4,0,0,0,        0,0,1,1,1,        0,4,0);
    add(0,0,1,5,0,0,0,        0,1,1,1,1,        0,4,0);
    add(0,0,1,5,0,0,1,        0,1,1,1,1,        0,3,0);
    add(0,0,1,5,0,0,1,        0,0,1,1,2,        0,3,0);
    add(0,0,0,0,0,0,1,        0,0,1,1,3,        0,2,0);
    add(0,0,0,0,0,0,1,        0,0,1,1,4,        0,1,0);
    add(0,0,0,0,0,0,1,        0,0,1,1,5,        0,0,0);
    add(0,0,0,0,0,0,1,        0,0,1,0,0,        0,0,0);
    // fill input FIFO, then READ while full with in_valid held
    add(0,0,0,0,1,'h10,0,     0,0,1,0,0,        1,0,0);
    add(0,0,0,0,1,'h11,0,     'h10,0,1,0,0,     2,0,0);
    add(0,0,0,0,1,'h12,0,     'h10,0,1,0,0,     3,0,0);
    add(0,0,0,0,1,'h13,0,     'h10,0,1,0,0,     4,0,0);
    add(0,1,0,0,1,'h14,0,     'h10,0,0,0,0,     3,0,0);
    add(0,0,0,0,1,'h14,0,     'h11,0,1,0,0,     4,0,0);
    // simultaneous READ and WRITE sets sticky err
    add(0,1,1,'h99,0,0,0,     'h11,0,0,0,0,     4,0,1);
    add(0,0,0,0,0,0,0,        'h11,0,0,0,0,     4,0,1);
    add(0,1,0,0,0,0,0,        'h11,0,0,0,0,     3,0,1);
    add(0,1,0,0,0,0,0,        'h12,0,1,0,0,     2,0,1);
    add(0,0,1,'h21,0,0,0,     'h13,0,1,0,0,     2,1,1);
    add(0,0,1,'h22,0,0,0,     'h13,0,1,1,'h21,  2,2,1);
    // reset with both FIFOs at 2 entries wins over concurrent traffic
    add(1,1,0,0,1,'h55,1,     'h13,0,1,1,'h21,  0,0,0);
    add(0,0,0,0,0,0,0,        0,0,1,0,0,        0,0,0);
    // WRITE held through reset is serviced on the first normal edge
    add(1,0,1,'h77,0,0,0,     0,0,1,0,0,        0,0,0);
    add(0,0,1,'h77,0,0,0,     0,0,1,0,0,        0,1,0);
    add(0,0,0,0,0,0,1,        0,0,1,1,'h77,     0,0,0);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].rd, tbl[i].wr, tbl[i].wdata,
                    tbl[i].iv, tbl[i].idata, tbl[i].ordy);
      checkOutput($sformatf("v%0d cpu_rdata", i), cpu_rdata, tbl[i].p_rdata);
      checkOutput($sformatf("v%0d cpu_stall", i), 16'(cpu_stall), 16'(tbl[i].p_stall));
      checkOutput($sformatf("v%0d in_ready", i), 16'(in_ready), 16'(tbl[i].p_inrdy));
      checkOutput($sformatf("v%0d out_valid", i), 16'(out_valid), 16'(tbl[i].p_ovalid));
      if (tbl[i].p_ovalid)
        checkOutput($sformatf("v%0d out_data", i), out_data, tbl[i].p_odata);
      @(posedge clk);
      #1;
      checkOutput($sformatf("v%0d in_count", i), 16'(in_count), 16'(tbl[i].q_in));
      checkOutput($sformatf("v%0d out_count", i), 16'(out_count), 16'(tbl[i].q_out));
      checkOutput($sformatf("v%0d err", i), 16'(err), 16'(tbl[i].q_err));
    end

    // The table ends with both FIFOs empty and err clear.
    in_q.delete();
    out_q.delete();
    m_err = 1'b0;
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(49) == 0),
                    1'($urandom_range(2) == 0), 1'($urandom_range(2) == 0),
                    16'($urandom), 1'($urandom_range(1)), 16'($urandom),
                    1'($urandom_range(1)));
      checkModel(n);
      @(posedge clk);
      modelStep();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hmmm_io_port.md
HMMM_IO_PORT -- requirements
Module: hmmm_io_port

Interface
REQ-001 The block SHALL have one parameter, DEPTH, default 4: entries per FIFO, a power of 2 and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port cpu_rd_req, input, 1 bit: the core is executing READ this cycle.
REQ-005 The block SHALL have port cpu_wr_req, input, 1 bit: the core is executing WRITE this cycle.
REQ-006 The block SHALL have port cpu_wdata, input, 16 bits: the rX value for WRITE.
REQ-007 The block SHALL have port cpu_rdata, output, 16 bits: the value written to rX for READ.
REQ-008 The block SHALL have port cpu_stall, output, 1 bit: tells the core to hold PC and suppress its register write.
REQ-009 The block SHALL have port in_valid, input, 1 bit: the external source presents a word.
REQ-010 The block SHALL have port in_data, input, 16 bits: the external source word.
REQ-011 The block SHALL have port in_ready, output, 1 bit: the input FIFO can accept a word.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the output FIFO head is valid.
REQ-013 The block SHALL have port out_data, output, 16 bits: the output FIFO head word.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the external sink accepts a word.
REQ-015 The block SHALL have port in_count, output, clog2(DEPTH)+1 bits: input FIFO occupancy.
REQ-016 The block SHALL have port out_count, output, clog2(DEPTH)+1 bits: output FIFO occupancy.
REQ-017 The block SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-018 The block SHALL contain two independent FIFOs, input and output, each DEPTH x 16 bits, with read/write pointers that wrap modulo DEPTH.
REQ-019 The block SHALL drive in_ready = (in_count != DEPTH) and SHALL push in_data into the input FIFO on an edge where in_valid && in_ready.
REQ-020 The block SHALL drive cpu_rdata combinationally from the input FIFO head, and SHALL drive 16'h0000 when the input FIFO is empty.
REQ-021 The block SHALL pop the input FIFO on an edge where cpu_rd_req && !cpu_wr_req && in_count != 0.
REQ-022 The block SHALL push cpu_wdata into the output FIFO on an edge where cpu_wr_req && !cpu_rd_req && out_count != DEPTH.
REQ-023 The block SHALL drive out_valid = (out_count != 0) and out_data from the output FIFO head, and SHALL pop on an edge where out_valid && out_ready.
REQ-024 The block SHALL drive cpu_stall combinationally as (cpu_rd_req && !cpu_wr_req && in_count == 0) || (cpu_wr_req && !cpu_rd_req && out_count == DEPTH).
REQ-025 The block SHALL complete a non-stalled READ or WRITE in the same cycle (zero added latency); a stalled request SHALL retry every cycle until it is serviced.
REQ-026 On a simultaneous push and pop on one FIFO, the block SHALL perform both operations and leave the count unchanged.
REQ-027 The block SHALL use no bypass: a word pushed into an empty FIFO SHALL become visible at that FIFO's head one cycle later, and a READ to an empty input FIFO SHALL stall during the push cycle.
REQ-028 When a FIFO is full and a pop occurs in the same cycle, the block SHALL use ready/stall values from the start-of-cycle count, so no push occurs that cycle.
REQ-029 When cpu_rd_req && cpu_wr_req, the block SHALL do no CPU push or pop, SHALL hold cpu_stall low, and SHALL set err to 1 on that edge.
REQ-030 Once set, err SHALL remain 1 until reset.
REQ-031 External-side transfers SHALL proceed regardless of CPU request state.

Reset
REQ-032 On an edge with reset=1, the block SHALL clear all pointers and both counts, and SHALL clear err to 0.
REQ-033 During and after reset, outputs SHALL take these values: in_ready=1, out_valid=0, cpu_stall=0 unless a READ is pending on the now-empty FIFO, and cpu_rdata=0.
REQ-034 Reset SHALL take priority over all simultaneous pushes and pops, and FIFO contents SHALL be discarded.
REQ-035 Reset mid-stall SHALL empty the FIFOs; a WRITE still asserted after reset SHALL be serviced on the next non-reset edge.

Verification
REQ-036 The bench SHALL cover: push 16'h0005, then 16'h0007 via in_valid; then READ on two consecutive cycles -> cpu_rdata=0005 then 0007, cpu_stall=0, in_count 2->1->0.
REQ-037 The bench SHALL cover: READ with the input FIFO empty for 3 cycles, then push 16'h00AA -> cpu_stall=1 for 4 cycles total, cpu_rdata=00AA with stall=0 on the cycle after the push.
REQ-038 The bench SHALL cover: out_ready=0 and WRITE of 1,2,3,4,5 with DEPTH=4 -> the 5th WRITE stalls with out_count=4; raising out_ready drains 1,2,3,4,5 in order.
REQ-039 The bench SHALL cover: input FIFO full with in_valid=1 while READ pops -> no push that cycle, in_count=3 after the edge, and the push occurs next cycle.
REQ-040 The bench SHALL cover: cpu_rd_req=cpu_wr_req=1 for one cycle -> counts unchanged, cpu_stall=0, err=1 and err stays 1 until reset.
REQ-041 The bench SHALL cover: reset asserted with both FIFOs holding 2 entries -> next cycle in_count=out_count=0, out_valid=0, err=0.
